// File: rtl/action_issuer.sv
// Action issuer: turns lookup results into single-cycle writes into a credit-limited action FIFO.
// Optional ACTION_ISSUER_MISS_TO_CPU_EN: a table miss forwards the packet to CPU_DST_PORT instead of a no-op.
module action_issuer #(
    parameter int          TABLE_DEPTH_BITS     = 5,
    parameter int          NUM_CREDITS          = 4,
    parameter logic [15:0] CPU_DST_PORT         = 16'h0002,
    parameter int          OF_ACTION_DATA_WIDTH = 32,
    parameter int          OF_ACTION_CTRL_WIDTH = 8,
    parameter int          OF_DST_PORT_POS      = 0,
    localparam int         CREDIT_W             = $clog2(NUM_CREDITS + 1)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            lookup_valid,
    input  logic                            lookup_hit,
    input  logic [TABLE_DEPTH_BITS-1:0]     lookup_index,
    output logic                            lookup_rdy,
    input  logic                            tbl_wr_en,
    input  logic [TABLE_DEPTH_BITS-1:0]     tbl_wr_addr,
    input  logic [OF_ACTION_DATA_WIDTH-1:0] tbl_wr_data,
    input  logic [OF_ACTION_CTRL_WIDTH-1:0] tbl_wr_ctrl,
    output logic [OF_ACTION_DATA_WIDTH-1:0] action_data_bus,
    output logic [OF_ACTION_CTRL_WIDTH-1:0] action_ctrl_bus,
    output logic                            action_valid,
    input  logic                            action_consumed,
    output logic                            credit_err,
    output logic [1:0]                      dbg_state_o,
    output logic [CREDIT_W-1:0]             dbg_credits_o
);

    localparam int DEPTH = 2 ** TABLE_DEPTH_BITS;

`ifdef ACTION_ISSUER_MISS_TO_CPU_EN
    localparam logic [OF_ACTION_DATA_WIDTH-1:0] MISS_DATA =
        OF_ACTION_DATA_WIDTH'(CPU_DST_PORT) << OF_DST_PORT_POS;
    localparam logic [OF_ACTION_CTRL_WIDTH-1:0] MISS_CTRL = OF_ACTION_CTRL_WIDTH'(1);
`else
    localparam logic [OF_ACTION_DATA_WIDTH-1:0] MISS_DATA = '0;
    localparam logic [OF_ACTION_CTRL_WIDTH-1:0] MISS_CTRL = '0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t                          state_q, state_d;
    logic [CREDIT_W-1:0]             credits_q, credits_d;
    logic                            hit_q, hit_d;
    logic [TABLE_DEPTH_BITS-1:0]     idx_q, idx_d;
    logic [OF_ACTION_DATA_WIDTH-1:0] data_q, data_d;
    logic [OF_ACTION_CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
    logic                            valid_q, valid_d;
    logic                            err_q, err_d;
    logic                            issuing;

    logic [OF_ACTION_DATA_WIDTH-1:0] tbl_data_q [DEPTH];
    logic [OF_ACTION_CTRL_WIDTH-1:0] tbl_ctrl_q [DEPTH];

    // Table contents survive reset; the read in READ sees pre-write contents (read-first).
    always_ff @(posedge clk) begin
        if (tbl_wr_en) begin
            tbl_data_q[tbl_wr_addr] <= tbl_wr_data;
            tbl_ctrl_q[tbl_wr_addr] <= tbl_wr_ctrl;
        end
    end

    assign lookup_rdy = (state_q == IDLE) && (credits_q != '0);
    assign issuing    = (state_q == ISSUE);

    always_comb begin
        state_d = state_q;
        hit_d   = hit_q;
        idx_d   = idx_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (lookup_valid && lookup_rdy) begin
                    hit_d   = lookup_hit;
                    idx_d   = lookup_index;
                    state_d = READ;
                end
            end
            READ: begin
                valid_d = 1'b1;
                state_d = ISSUE;
                if (hit_q) begin
                    data_d = tbl_data_q[idx_q];
                    ctrl_d = tbl_ctrl_q[idx_q];
                end else begin
                    data_d = MISS_DATA;
                    ctrl_d = MISS_CTRL;
                end
            end
            ISSUE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A simultaneous issue and consume cancel; a consume at full credits is an error.
    always_comb begin
        credits_d = credits_q;
        err_d     = err_q;
        if (issuing && !action_consumed) begin
            credits_d = credits_q - 1'b1;
        end else if (action_consumed && !issuing) begin
            if (credits_q == CREDIT_W'(NUM_CREDITS)) begin
                err_d = 1'b1;
            end else begin
                credits_d = credits_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            credits_q <= CREDIT_W'(NUM_CREDITS);
            hit_q     <= 1'b0;
            idx_q     <= '0;
            data_q    <= '0;
            ctrl_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            credits_q <= credits_d;
            hit_q     <= hit_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            ctrl_q    <= ctrl_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    assign action_data_bus = data_q;
    assign action_ctrl_bus = ctrl_q;
    assign action_valid    = valid_q;
    assign credit_err      = err_q;
    assign dbg_state_o     = state_q;
    assign dbg_credits_o   = credits_q;

endmodule

// File: tb/tb_action_issuer.sv
// Self-checking bench for action_issuer: directed scenarios plus random traffic against
// a schedule-based reference model (acceptance at cycle N -> action expected at cycle N+2).
module tb_action_issuer;
    localparam int TB  = 5;
    localparam int NC  = 4;
    localparam int DW  = 32;
    localparam int CTW = 8;
    localparam int CW  = $clog2(NC + 1);

    logic           clk = 1'b0;
    logic           reset;
    logic           lookup_valid, lookup_hit;
    logic [TB-1:0]  lookup_index;
    logic           lookup_rdy;
    logic           tbl_wr_en;
    logic [TB-1:0]  tbl_wr_addr;
    logic [DW-1:0]  tbl_wr_data;
    logic [CTW-1:0] tbl_wr_ctrl;
    logic [DW-1:0]  action_data_bus;
    logic [CTW-1:0] action_ctrl_bus;
    logic           action_valid, action_consumed, credit_err;
    logic [1:0]     dbg_state;
    logic [CW-1:0]  dbg_credits;

    action_issuer #(
        .TABLE_DEPTH_BITS(TB), .NUM_CREDITS(NC), .CPU_DST_PORT(16'h0002),
        .OF_ACTION_DATA_WIDTH(DW), .OF_ACTION_CTRL_WIDTH(CTW), .OF_DST_PORT_POS(0)
    ) dut (
        .clk(clk), .reset(reset),
        .lookup_valid(lookup_valid), .lookup_hit(lookup_hit),
        .lookup_index(lookup_index), .lookup_rdy(lookup_rdy),
        .tbl_wr_en(tbl_wr_en), .tbl_wr_addr(tbl_wr_addr),
        .tbl_wr_data(tbl_wr_data), .tbl_wr_ctrl(tbl_wr_ctrl),
        .action_data_bus(action_data_bus), .action_ctrl_bus(action_ctrl_bus),
        .action_valid(action_valid), .action_consumed(action_consumed),
        .credit_err(credit_err), .dbg_state_o(dbg_state), .dbg_credits_o(dbg_credits)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

`ifdef ACTION_ISSUER_MISS_TO_CPU_EN
    localparam logic [DW-1:0]  MISS_DATA = 32'h0000_0002;
    localparam logic [CTW-1:0] MISS_CTRL = 8'h01;
`else
    localparam logic [DW-1:0]  MISS_DATA = 32'h0;
    localparam logic [CTW-1:0] MISS_CTRL = 8'h00;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // reference model
    typedef struct {
        int due;
        bit hit;
        int idx;
    } pend_t;

    pend_t           pend_q[$];
    logic [DW+CTW-1:0] exp_q[$];
    int              cyc = 0;
    int              m_credits = NC;
    bit              m_err = 1'b0;
    logic [DW-1:0]   m_data = '0;
    logic [CTW-1:0]  m_ctrl = '0;
    logic [DW-1:0]   m_tbl_data [2**TB];
    logic [CTW-1:0]  m_tbl_ctrl [2**TB];

    always @(posedge clk) begin
        bit rdy_now;
        bit issuing;
        rdy_now = (pend_q.size() == 0) && (m_credits > 0);
        if (reset) begin
            pend_q.delete();
            exp_q.delete();
            m_credits = NC;
            m_err     = 1'b0;
            m_data    = '0;
            m_ctrl    = '0;
        end else begin
            issuing = (pend_q.size() > 0) && (pend_q[0].due == cyc);
            if (pend_q.size() > 0 && pend_q[0].due == cyc + 1) begin
                if (pend_q[0].hit) begin
                    m_data = m_tbl_data[pend_q[0].idx];
                    m_ctrl = m_tbl_ctrl[pend_q[0].idx];
                end else begin
                    m_data = MISS_DATA;
                    m_ctrl = MISS_CTRL;
                end
                exp_q.push_back({m_ctrl, m_data});
            end
            if (issuing) void'(pend_q.pop_front());
            if (issuing && !action_consumed) m_credits = m_credits - 1;
            else if (action_consumed && !issuing) begin
                if (m_credits == NC) m_err = 1'b1;
                else m_credits = m_credits + 1;
            end
            if (rdy_now && lookup_valid)
                pend_q.push_back('{cyc + 2, lookup_hit, int'(lookup_index)});
        end
        if (tbl_wr_en) begin
            m_tbl_data[tbl_wr_addr] = tbl_wr_data;
            m_tbl_ctrl[tbl_wr_addr] = tbl_wr_ctrl;
        end
        cyc++;
    end

    // scoreboard: compare every cycle on the falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("lookup_rdy", lookup_rdy, (pend_q.size() == 0) && (m_credits > 0));
            check("action_valid", action_valid, (pend_q.size() > 0) && (pend_q[0].due == cyc));
            check("action_data_bus", action_data_bus, m_data);
            check("action_ctrl_bus", action_ctrl_bus, m_ctrl);
            check("credit_err", credit_err, m_err);
            check("credits", dbg_credits, m_credits);
            if (action_valid) begin
                if (exp_q.size() == 0) check("unexpected_action", 1'b1, 1'b0);
                else check("payload", {action_ctrl_bus, action_data_bus}, exp_q.pop_front());
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Returns positioned in the ISSUE cycle of the accepted lookup.
    task automatic accept(input bit hit, input logic [TB-1:0] idx);
        int w = 0;
        while (!lookup_rdy && w < 50) begin
            tick();
            w++;
        end
        if (w == 50) check("rdy_timeout", 1'b0, 1'b1);
        lookup_valid = 1'b1;
        lookup_hit   = hit;
        lookup_index = idx;
        tick();
        lookup_valid = 1'b0;
        check("read_no_valid", action_valid, 1'b0);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nvalid;
        reset = 1'b1; lookup_valid = 1'b0; lookup_hit = 1'b0; lookup_index = '0;
        tbl_wr_en = 1'b0; tbl_wr_addr = '0; tbl_wr_data = '0; tbl_wr_ctrl = '0;
        action_consumed = 1'b0;
        tick();
        chk_en = 1'b1;

        // fill the whole table while reset is held
        for (int i = 0; i < 2**TB; i++) begin
            tbl_wr_en   = 1'b1;
            tbl_wr_addr = TB'(i);
            tbl_wr_data = (i == 3) ? 32'h0000_0004 : $urandom;
            tbl_wr_ctrl = (i == 3) ? 8'h01 : 8'($urandom);
            tick();
        end
        tbl_wr_en = 1'b0;
        reset = 1'b0;
        check("rst_rdy", lookup_rdy, 1'b1);
        check("rst_valid", action_valid, 1'b0);
        check("rst_data", action_data_bus, 32'h0);
        check("rst_ctrl", action_ctrl_bus, 8'h0);
        check("rst_err", credit_err, 1'b0);
        check("rst_credits", dbg_credits, 3'd4);
        check("rst_state", dbg_state, 2'd0);

        // consume at full credits: sticky error, credits unchanged
        action_consumed = 1'b1;
        tick();
        action_consumed = 1'b0;
        check("err_set", credit_err, 1'b1);
        check("err_credits", dbg_credits, 3'd4);
        tick(); tick();
        check("err_sticky", credit_err, 1'b1);
        do_reset();
        check("err_cleared", credit_err, 1'b0);

        // hit on entry 3: valid exactly two cycles after acceptance
        lookup_valid = 1'b1; lookup_hit = 1'b1; lookup_index = 5'd3;
        tick();
        lookup_valid = 1'b0;
        check("hit_n1_valid", action_valid, 1'b0);
        check("hit_n1_state", dbg_state, 2'd1);
        tick();
        check("hit_n2_valid", action_valid, 1'b1);
        check("hit_n2_ctrl", action_ctrl_bus, 8'h01);
        check("hit_n2_dst", action_data_bus[15:0], 16'h0004);
        tick();
        check("hit_n3_valid", action_valid, 1'b0);
        check("hit_hold_data", action_data_bus[15:0], 16'h0004);
        check("hit_credits", dbg_credits, 3'd3);

        // exhaust credits, then release one
        do_reset();
        nvalid = 0;
        for (int i = 0; i < 4; i++) begin
            accept(1'b1, TB'($urandom_range(0, 31)));
            if (action_valid) nvalid++;
            tick();
        end
        check("four_valids", nvalid, 4);
        check("exhaust_rdy", lookup_rdy, 1'b0);
        check("exhaust_credits", dbg_credits, 3'd0);
        lookup_valid = 1'b1;
        tick(); tick();
        check("exhaust_still_idle", dbg_state, 2'd0);
        lookup_valid = 1'b0;
        action_consumed = 1'b1;
        tick();
        action_consumed = 1'b0;
        check("release_rdy", lookup_rdy, 1'b1);

        // consume coincident with issue at credits=1
        do_reset();
        for (int i = 0; i < 3; i++) begin
            accept(1'b1, 5'd3);
            tick();
        end
        check("pre_coinc_credits", dbg_credits, 3'd1);
        accept(1'b1, 5'd3);
        action_consumed = 1'b1;
        check("coinc_valid", action_valid, 1'b1);
        tick();
        action_consumed = 1'b0;
        check("coinc_credits", dbg_credits, 3'd1);
        check("coinc_rdy", lookup_rdy, 1'b1);

        // miss action
        do_reset();
        accept(1'b0, 5'd3);
        check("miss_valid", action_valid, 1'b1);
        check("miss_ctrl", action_ctrl_bus, MISS_CTRL);
        check("miss_data", action_data_bus, MISS_DATA);
        tick();
        check("miss_credits", dbg_credits, 3'd3);

        // reset during READ discards the action; table survives
        lookup_valid = 1'b1; lookup_hit = 1'b1; lookup_index = 5'd3;
        tick();
        lookup_valid = 1'b0;
        check("rr_in_read", dbg_state, 2'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rr_state", dbg_state, 2'd0);
        check("rr_credits", dbg_credits, 3'd4);
        for (int i = 0; i < 3; i++) begin
            check("rr_no_valid", action_valid, 1'b0);
            tick();
        end
        accept(1'b1, 5'd3);
        check("rr_tbl_ctrl", action_ctrl_bus, 8'h01);
        check("rr_tbl_data", action_data_bus, 32'h0000_0004);
        tick();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            reset           = ($urandom_range(0, 299) == 0);
            lookup_valid    = $urandom_range(0, 1);
            lookup_hit      = ($urandom_range(0, 3) != 0);
            lookup_index    = TB'($urandom_range(0, 31));
            action_consumed = ($urandom_range(0, 2) == 0);
            tbl_wr_en       = ($urandom_range(0, 3) == 0);
            tbl_wr_addr     = TB'($urandom_range(0, 31));
            tbl_wr_data     = $urandom;
            tbl_wr_ctrl     = 8'($urandom);
            tick();
        end
        reset = 1'b0; lookup_valid = 1'b0; action_consumed = 1'b0; tbl_wr_en = 1'b0;
        repeat (5) tick();
        check("drain_exp_q", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
